// File: rtl/rx_validation_fifo.sv
// Receive validation stage: queues error-free UART frames in a first-word-fall-through FIFO
// and keeps sticky overflow plus saturating frame/parity error counters. Optional macro: RX_ZERO_DROP_EN.
module rx_validation_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [DATA_WIDTH-1:0]      rx_data,
   input  logic                       rx_strobe,
   input  logic                       rx_ferror,
   input  logic                       rx_perror,
   output logic                       rx_valid,
   input  logic                       rx_ready,
   output logic [DATA_WIDTH-1:0]      rx_dout,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow,
   output logic [CNT_WIDTH-1:0]       ferr_count,
   output logic [CNT_WIDTH-1:0]       perr_count,
   input  logic                       clr_status
`ifdef RX_ZERO_DROP_EN
   ,output logic [CNT_WIDTH-1:0]      zero_drop_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   // Write side is ACTIVE while space remains; read side is ACTIVE while an entry is held.
   typedef enum logic {WR_IDLE = 1'b0, WR_ACTIVE = 1'b1} wr_state_t;
   typedef enum logic {RD_IDLE = 1'b0, RD_ACTIVE = 1'b1} rd_state_t;

   wr_state_t wr_state_r, wr_state_nxt_s;
   rd_state_t rd_state_r, rd_state_nxt_s;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]         wr_ptr_r, wr_ptr_nxt_s;
   logic [AW-1:0]         rd_ptr_r, rd_ptr_nxt_s;
   logic [LW-1:0]         level_r, level_nxt_s;
   logic [DATA_WIDTH-1:0] dout_r, dout_nxt_s;
   logic                  ovf_r, ovf_nxt_s;
   logic [CNT_WIDTH-1:0]  ferr_cnt_r, ferr_cnt_nxt_s;
   logic [CNT_WIDTH-1:0]  perr_cnt_r, perr_cnt_nxt_s;

   logic clean_s, good_s, full_s, pop_s, push_s, drop_s;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] base,
                                                     input logic                 ev);
      if (ev && (base != {CNT_WIDTH{1'b1}})) begin
         sat_inc = base + CNT_WIDTH'(1);
      end else begin
         sat_inc = base;
      end
   endfunction

   assign clean_s = rx_strobe & ~rx_ferror & ~rx_perror;
`ifdef RX_ZERO_DROP_EN
   logic                 zero_s;
   logic [CNT_WIDTH-1:0] zero_cnt_r, zero_cnt_nxt_s;
   assign zero_s = clean_s & (rx_data == {DATA_WIDTH{1'b0}});
   assign good_s = clean_s & ~zero_s;
`else
   assign good_s = clean_s;
`endif
   assign full_s = (wr_state_r == WR_IDLE);
   assign pop_s  = (rd_state_r == RD_ACTIVE) & rx_ready;
   assign push_s = good_s & (~full_s | pop_s);
   assign drop_s = good_s & full_s & ~pop_s;

   // Next pointers, level and the head word that will be presented after this edge.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      level_nxt_s  = level_r;
      dout_nxt_s   = {DATA_WIDTH{1'b0}};
      if (push_s) begin
         wr_ptr_nxt_s = wr_ptr_r + AW'(1);
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + AW'(1);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s && !pop_s) begin
         level_nxt_s = level_r + LW'(1);
      end else if (!push_s && pop_s) begin
         level_nxt_s = level_r - LW'(1);
      end else begin
         level_nxt_s = level_r;
      end
      // The incoming word becomes the head when nothing older survives this edge.
      if (level_nxt_s == LW'(0)) begin
         dout_nxt_s = {DATA_WIDTH{1'b0}};
      end else if ((level_r == LW'(0)) || (pop_s && (level_r == LW'(1)))) begin
         dout_nxt_s = rx_data;
      end else begin
         dout_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Write and read controller next-state logic.
   always_comb begin
      wr_state_nxt_s = wr_state_r;
      rd_state_nxt_s = rd_state_r;
      case (wr_state_r)
         WR_ACTIVE: begin
            if (push_s && !pop_s && (level_r == LW'(DEPTH - 1))) wr_state_nxt_s = WR_IDLE;
            else                                                  wr_state_nxt_s = WR_ACTIVE;
         end
         WR_IDLE: begin
            if (pop_s && !push_s) wr_state_nxt_s = WR_ACTIVE;
            else                  wr_state_nxt_s = WR_IDLE;
         end
         default: wr_state_nxt_s = WR_ACTIVE;
      endcase
      case (rd_state_r)
         RD_IDLE: begin
            if (push_s) rd_state_nxt_s = RD_ACTIVE;
            else        rd_state_nxt_s = RD_IDLE;
         end
         RD_ACTIVE: begin
            if (pop_s && !push_s && (level_r == LW'(1))) rd_state_nxt_s = RD_IDLE;
            else                                          rd_state_nxt_s = RD_ACTIVE;
         end
         default: rd_state_nxt_s = RD_IDLE;
      endcase
   end

   // Status: a coincident clear is applied first so the same-cycle event still registers.
   always_comb begin
      ovf_nxt_s      = (clr_status ? 1'b0 : ovf_r) | drop_s;
      ferr_cnt_nxt_s = sat_inc(clr_status ? {CNT_WIDTH{1'b0}} : ferr_cnt_r, rx_strobe & rx_ferror);
      perr_cnt_nxt_s = sat_inc(clr_status ? {CNT_WIDTH{1'b0}} : perr_cnt_r, rx_strobe & rx_perror);
`ifdef RX_ZERO_DROP_EN
      zero_cnt_nxt_s = sat_inc(clr_status ? {CNT_WIDTH{1'b0}} : zero_cnt_r, zero_s);
`endif
   end

   // State, pointer, storage and status registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_state_r <= WR_ACTIVE;
         rd_state_r <= RD_IDLE;
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= {LW{1'b0}};
         dout_r     <= {DATA_WIDTH{1'b0}};
         ovf_r      <= 1'b0;
         ferr_cnt_r <= {CNT_WIDTH{1'b0}};
         perr_cnt_r <= {CNT_WIDTH{1'b0}};
`ifdef RX_ZERO_DROP_EN
         zero_cnt_r <= {CNT_WIDTH{1'b0}};
`endif
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         wr_state_r <= wr_state_nxt_s;
         rd_state_r <= rd_state_nxt_s;
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         level_r    <= level_nxt_s;
         dout_r     <= dout_nxt_s;
         ovf_r      <= ovf_nxt_s;
         ferr_cnt_r <= ferr_cnt_nxt_s;
         perr_cnt_r <= perr_cnt_nxt_s;
`ifdef RX_ZERO_DROP_EN
         zero_cnt_r <= zero_cnt_nxt_s;
`endif
         if (push_s) begin
            mem_r[wr_ptr_r] <= rx_data;
         end
      end
   end

   assign rx_valid   = (rd_state_r == RD_ACTIVE);
   assign rx_dout    = dout_r;
   assign fifo_level = level_r;
   assign overflow   = ovf_r;
   assign ferr_count = ferr_cnt_r;
   assign perr_count = perr_cnt_r;
`ifdef RX_ZERO_DROP_EN
   assign zero_drop_count = zero_cnt_r;
`endif

endmodule
